// File: rtl/cve2_prefetch_queue.sv
// cve2_prefetch_queue
// Instruction prefetch queue: issues word-aligned OBI fetches, tracks
// outstanding requests, discards stale responses after a redirect and
// buffers fetched words in a small FIFO for the decoder.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), synchronous active-low reset
//   req_i                  fetch enable (issue only; queued entries stay valid)
//   branch_i, addr_i       redirect strobe and target (forced word-aligned)
//   ready_i                consumer ready; head pops on valid_o & ready_i
//   valid_o, rdata_o,      head entry: instruction word, its word address
//   addr_o, err_o          and the bus error flag of that word
//   instr_req_o,           OBI request and address
//   instr_addr_o
//   instr_gnt_i,           OBI grant and response
//   instr_rvalid_i,
//   instr_rdata_i,
//   instr_err_i
//   busy_o                 request on the bus or responses still expected
//   stall_cnt_o            starvation cycle counter
//
// Optional feature: define CVE2_PREFETCH_PERF_EN to build the saturating
// starvation counter; otherwise stall_cnt_o is tied to zero.
module cve2_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUTS = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o,
  output logic [31:0] stall_cnt_o
);

  localparam int unsigned   PW         = $clog2(DEPTH);
  localparam int unsigned   CW         = 6;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_OUTS_C = CW'(MAX_OUTS);
  localparam logic [PW-1:0] LAST_C     = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;          // address presented / next to fetch
  logic [31:0]   tgt_q, tgt_d;            // resume address after a HOLD grant
  logic [31:0]   rsp_addr_q, rsp_addr_d;  // word address of next kept response
  logic [CW-1:0] out_q, out_d;            // granted, unanswered requests
  logic [CW-1:0] disc_q, disc_d;          // responses still to be dropped
  logic [CW-1:0] cnt_q, cnt_d;            // FIFO occupancy
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          out_en_q, out_en_d;      // low for the first cycle after reset

  logic [31:0]   mem_rdata_q [DEPTH];
  logic [31:0]   mem_addr_q  [DEPTH];
  logic          mem_err_q   [DEPTH];

  logic          en_s, credit_s, instr_req_raw_s, instr_req_s, gnt_s;
  logic          rvalid_s, push_s, pop_s, drop_s, valid_s;
  logic          hold_enter_s, hold_gnt_s;
  logic [31:0]   target_s;
  logic          unused_addr_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == LAST_C) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign unused_addr_s = ^addr_i[1:0];
  assign target_s      = {addr_i[31:2], 2'b00};

  // Outputs are forced low while reset is sampled and one cycle after it.
  assign en_s         = rst_ni & out_en_q;
  // A new request needs a free outstanding slot and a FIFO slot reserved for its response.
  assign credit_s     = (out_q < MAX_OUTS_C) && ((cnt_q + out_q) < DEPTH_C);
  assign instr_req_s  = instr_req_raw_s & en_s;
  assign gnt_s        = instr_req_s & instr_gnt_i;
  // Responses with nothing outstanding (e.g. from before reset) are ignored.
  assign rvalid_s     = instr_rvalid_i & (out_q != {CW{1'b0}});
  assign push_s       = rvalid_s & ~branch_i & (disc_q == {CW{1'b0}});
  assign drop_s       = rvalid_s & ~branch_i & (disc_q != {CW{1'b0}});
  assign valid_s      = (cnt_q != {CW{1'b0}}) & ~branch_i & en_s;
  assign pop_s        = valid_s & ready_i;
  assign hold_enter_s = (state_q == S_REQ) & instr_req_s & ~instr_gnt_i & (~req_i | branch_i);
  assign hold_gnt_s   = (state_q == S_HOLD) & gnt_s;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_i || branch_i) state_d = S_REQ;
        else                   state_d = S_IDLE;
      end
      S_REQ: begin
        if (hold_enter_s)            state_d = S_HOLD;
        else if (!req_i && !branch_i) state_d = S_IDLE;
        else                         state_d = S_REQ;
      end
      S_HOLD: begin
        if (gnt_s) state_d = req_i ? S_REQ : S_IDLE;
        else       state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output logic: HOLD keeps its request up regardless of credit.
  always_comb begin
    instr_req_raw_s = 1'b0;
    case (state_q)
      S_IDLE:  instr_req_raw_s = 1'b0;
      S_REQ:   instr_req_raw_s = credit_s;
      S_HOLD:  instr_req_raw_s = 1'b1;
      default: instr_req_raw_s = 1'b0;
    endcase
  end

  // Fetch address update; a held request keeps its address, the redirect target waits in tgt.
  always_comb begin
    addr_d = addr_q;
    tgt_d  = tgt_q;
    case (state_q)
      S_IDLE: begin
        if (branch_i) addr_d = target_s;
        else          addr_d = addr_q;
      end
      S_REQ: begin
        // Held responses are discarded, so without a branch the same word is refetched.
        if (hold_enter_s)  tgt_d  = branch_i ? target_s : addr_q;
        else if (branch_i) addr_d = target_s;
        else if (gnt_s)    addr_d = addr_q + 32'd4;
        else               addr_d = addr_q;
      end
      S_HOLD: begin
        if (gnt_s)         addr_d = branch_i ? target_s : tgt_q;
        else if (branch_i) tgt_d  = target_s;
        else               tgt_d  = tgt_q;
      end
      default: addr_d = addr_q;
    endcase
  end

  // Outstanding, discard and FIFO bookkeeping.
  always_comb begin
    out_d      = out_q + CW'(gnt_s) - CW'(rvalid_s);
    out_en_d   = 1'b1;
    rsp_addr_d = rsp_addr_q;
    disc_d     = disc_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (branch_i) begin
      // Everything still on the bus after this cycle belongs to the old stream.
      disc_d     = out_q + CW'(gnt_s) - CW'(rvalid_s);
      rsp_addr_d = target_s;
      cnt_d      = {CW{1'b0}};
      wptr_d     = {PW{1'b0}};
      rptr_d     = {PW{1'b0}};
    end else begin
      disc_d     = disc_q + CW'(hold_gnt_s) - CW'(drop_s);
      rsp_addr_d = push_s ? rsp_addr_q + 32'd4 : rsp_addr_q;
      cnt_d      = cnt_q + CW'(push_s) - CW'(pop_s);
      wptr_d     = push_s ? ptr_inc(wptr_q) : wptr_q;
      rptr_d     = pop_s ? ptr_inc(rptr_q) : rptr_q;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q     <= 32'd0;
      tgt_q      <= 32'd0;
      rsp_addr_q <= 32'd0;
      out_q      <= {CW{1'b0}};
      disc_q     <= {CW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      wptr_q     <= {PW{1'b0}};
      rptr_q     <= {PW{1'b0}};
      out_en_q   <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      tgt_q      <= tgt_d;
      rsp_addr_q <= rsp_addr_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      out_en_q   <= out_en_d;
    end
  end

  // FIFO storage; contents are qualified by cnt_q so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_rdata_q[wptr_q] <= instr_rdata_i;
      mem_addr_q[wptr_q]  <= rsp_addr_q;
      mem_err_q[wptr_q]   <= instr_err_i;
    end
  end

  assign valid_o      = valid_s;
  assign rdata_o      = en_s ? mem_rdata_q[rptr_q] : 32'd0;
  assign addr_o       = en_s ? mem_addr_q[rptr_q] : 32'd0;
  assign err_o        = en_s & mem_err_q[rptr_q];
  assign instr_req_o  = instr_req_s;
  assign instr_addr_o = en_s ? addr_q : 32'd0;
  assign busy_o       = en_s & (instr_req_s | (out_q != {CW{1'b0}}));

`ifdef CVE2_PREFETCH_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Starvation counter: consumer and fetch both want data but none is available.
  always_comb begin
    if (en_s && req_i && ready_i && !valid_s && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
    else                                                                      stall_d = stall_q;
  end

  // Starvation counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = en_s ? stall_q : 32'd0;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cve2_prefetch_queue.sv
// Directed bench for cve2_prefetch_queue (DEPTH=4, MAX_OUTS=2).
// A small OBI memory model answers each grant one cycle later with
// rdata = ~addr and err = (addr == err_addr); popped entries are collected
// and compared against hand-derived address sequences.
module tb_cve2_prefetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = 32'd0;
  logic        instr_err_i = 1'b0;
  logic        busy_o;
  logic [31:0] stall_cnt_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } entry_t;

  entry_t      obs[$];
  logic [31:0] pend[$];
  bit          rsp_en = 1'b0;
  logic [31:0] err_addr = 32'h0000_0002;
  int          n_grant = 0;
  int          cyc_n = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  cve2_prefetch_queue #(.DEPTH(4), .MAX_OUTS(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i),
    .addr_i(addr_i), .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o),
    .addr_o(addr_o), .err_o(err_o), .instr_req_o(instr_req_o),
    .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: record handshakes mid-cycle, then drive the next bus response.
  task automatic step();
    entry_t e;
    logic [31:0] a;
    @(negedge clk_i);
    if (instr_req_o && instr_gnt_i) begin
      pend.push_back(instr_addr_o);
      n_grant++;
    end
    if (valid_o && ready_i) begin
      e.addr = addr_o; e.rdata = rdata_o; e.err = err_o; e.cyc = cyc_n;
      obs.push_back(e);
    end
    @(posedge clk_i); #1;
    cyc_n++;
    if (rsp_en && pend.size() > 0) begin
      a = pend.pop_front();
      instr_rvalid_i = 1'b1; instr_rdata_i = ~a; instr_err_i = (a == err_addr);
    end else begin
      instr_rvalid_i = 1'b0; instr_rdata_i = 32'd0; instr_err_i = 1'b0;
    end
  endtask

  task automatic begin_test(input logic [31:0] target, input logic rdy, input logic gnt, input bit rsp);
    obs.delete();
    n_grant = 0;
    ready_i = rdy; instr_gnt_i = gnt; rsp_en = rsp;
    req_i = 1'b1; branch_i = 1'b1; addr_i = target;
    step();
    branch_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    req_i = 1'b0; ready_i = 1'b1; instr_gnt_i = 1'b1; rsp_en = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (!busy_o && !valid_o && !instr_rvalid_i && pend.size() == 0) done = 1'b1;
    end
    check_eq({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  // Every kept fetch must appear once, in order, starting at base.
  task automatic check_seq(input string tag, input logic [31:0] base, input int ndisc);
    logic [31:0] exp;
    check_eq({tag, "_count"}, obs.size(), n_grant - ndisc);
    for (int i = 0; i < obs.size(); i++) begin
      exp = base + 32'(4 * i);
      check_eq({tag, "_addr"}, obs[i].addr, exp);
      check_eq({tag, "_rdata"}, obs[i].rdata, ~exp);
      check_eq({tag, "_err"}, 32'(obs[i].err), 32'(exp == err_addr));
    end
  endtask

  initial begin
    // Reset: outputs low while reset is sampled and in the cycle after.
    #1;
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_req", 32'(instr_req_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    step(); step();
    rst_ni = 1'b1;
    check_eq("post_rst_req", 32'(instr_req_o), 32'd0);
    check_eq("post_rst_addr", instr_addr_o, 32'd0);
    check_eq("post_rst_stall", stall_cnt_o, 32'd0);
    step(); step();

    // Streaming from 0x100, one response per cycle.
    begin_test(32'h0000_0100, 1'b1, 1'b1, 1'b1);
    step();
    check_eq("stream_nobypass", 32'(valid_o), 32'd0);
    step();
    check_eq("stream_first_valid", 32'(valid_o), 32'd1);
    check_eq("stream_first_addr", addr_o, 32'h0000_0100);
    repeat (4) step();
    drain("stream");
    check_seq("stream", 32'h0000_0100, 0);
    if (obs.size() >= 3) begin
      check_eq("stream_gap1", obs[1].cyc - obs[0].cyc, 32'd1);
      check_eq("stream_gap2", obs[2].cyc - obs[1].cyc, 32'd1);
    end

    // Unaligned target and 32-bit address wrap.
    begin_test(32'hFFFF_FFFB, 1'b1, 1'b1, 1'b1);
    repeat (4) step();
    drain("wrap");
    check_seq("wrap", 32'hFFFF_FFF8, 0);

    // Backpressure: 4 entries fill the FIFO, then issue stops.
    begin_test(32'h0000_0400, 1'b0, 1'b1, 1'b1);
    repeat (8) step();
    check_eq("bp_grants", n_grant, 32'd4);
    check_eq("bp_req_off", 32'(instr_req_o), 32'd0);
    check_eq("bp_busy", 32'(busy_o), 32'd0);
    check_eq("bp_head", addr_o, 32'h0000_0400);
    req_i = 1'b0;
    repeat (3) step();
    check_eq("bp_keep_valid", 32'(valid_o), 32'd1);
    check_eq("bp_keep_addr", addr_o, 32'h0000_0400);
    req_i = 1'b1; ready_i = 1'b1;
    repeat (6) step();
    drain("bp");
    check_seq("bp", 32'h0000_0400, 0);

    // Branch with two outstanding requests: both responses dropped.
    begin_test(32'h0000_0500, 1'b1, 1'b1, 1'b0);
    step(); step();
    check_eq("br2_maxouts", 32'(instr_req_o), 32'd0);
    branch_i = 1'b1; addr_i = 32'h0000_0200; rsp_en = 1'b1;
    step();
    branch_i = 1'b0;
    repeat (6) step();
    drain("br2");
    check_seq("br2", 32'h0000_0200, 2);

    // Branch while 0x10C is requested but not granted.
    begin_test(32'h0000_010C, 1'b1, 1'b0, 1'b1);
    check_eq("hold_req", 32'(instr_req_o), 32'd1);
    check_eq("hold_addr0", instr_addr_o, 32'h0000_010C);
    branch_i = 1'b1; addr_i = 32'h0000_0300;
    step();
    branch_i = 1'b0;
    check_eq("hold_addr1", instr_addr_o, 32'h0000_010C);
    step();
    check_eq("hold_addr2", instr_addr_o, 32'h0000_010C);
    check_eq("hold_req2", 32'(instr_req_o), 32'd1);
    instr_gnt_i = 1'b1;
    step();
    check_eq("hold_next_addr", instr_addr_o, 32'h0000_0300);
    repeat (5) step();
    drain("hold");
    check_seq("hold", 32'h0000_0300, 1);

    // Error response at 0x204 only.
    err_addr = 32'h0000_0204;
    begin_test(32'h0000_0200, 1'b1, 1'b1, 1'b1);
    repeat (5) step();
    drain("err");
    check_seq("err", 32'h0000_0200, 0);
    if (obs.size() >= 3) begin
      check_eq("err_hit", 32'(obs[1].err), 32'd1);
      check_eq("err_next", 32'(obs[2].err), 32'd0);
    end

    // Reset abandons a held request.
    begin_test(32'h0000_0600, 1'b1, 1'b0, 1'b1);
    req_i = 1'b0;
    step();
    check_eq("rhold_req", 32'(instr_req_o), 32'd1);
    rst_ni = 1'b0; #1;
    check_eq("rhold_gate", 32'(instr_req_o), 32'd0);
    step();
    rst_ni = 1'b1;
    check_eq("rhold_after", 32'(instr_req_o), 32'd0);
    check_eq("rhold_busy", 32'(busy_o), 32'd0);
    step();

    // Five starved cycles, then reset clears the counter.
    req_i = 1'b1; ready_i = 1'b1; instr_gnt_i = 1'b0;
    repeat (5) step();
    req_i = 1'b0;
`ifdef CVE2_PREFETCH_PERF_EN
    check_eq("stall_five", stall_cnt_o, 32'd5);
`else
    check_eq("stall_five", stall_cnt_o, 32'd0);
`endif
    check_eq("stall_valid", 32'(valid_o), 32'd0);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    check_eq("stall_rst", stall_cnt_o, 32'd0);
    check_eq("stall_rst_req", 32'(instr_req_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cve2_prefetch_queue.md
CVE2_PREFETCH_QUEUE -- requirements
Module: cve2_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (legal 2..16).
REQ-002 SHALL have parameter MAX_OUTS, default 2, meaning the maximum number of granted but unanswered bus requests (legal 1..DEPTH).
REQ-003 SHALL have port clk_i  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_i  input  1  fetch enable.
REQ-006 SHALL have port branch_i / addr_i  input  1 / 32  redirect strobe and target.
REQ-007 SHALL have port ready_i  input  1  consumer ready.
REQ-008 SHALL have port valid_o / rdata_o / addr_o / err_o  output  1 / 32 / 32 / 1  head entry.
REQ-009 SHALL have port instr_req_o / instr_addr_o  output  1 / 32  OBI request.
REQ-010 SHALL have port instr_gnt_i / instr_rvalid_i / instr_rdata_i / instr_err_i  input  1 / 1 / 32 / 1  OBI grant and response.
REQ-011 SHALL have port busy_o  output  1  high when instr_req_o=1 or outstanding!=0.
REQ-012 SHALL have port stall_cnt_o  output  32  starvation counter (see Configuration).

Function
REQ-013 SHALL fetch word-aligned only: the target is {addr_i[31:2],2'b00}, and each grant advances the fetch address by 4 with 32-bit wrap (FFFF_FFFC -> 0000_0000).
REQ-014 SHALL run FSM IDLE -> REQ on req_i=1 or branch_i=1; REQ -> HOLD when instr_req_o=1 & gnt=0 and (req_i drops or branch_i); HOLD -> REQ/IDLE on gnt; REQ -> IDLE when req_i=0 with no pending request.
REQ-015 SHALL assert instr_req_o in REQ only when outstanding<MAX_OUTS and occupancy+outstanding<DEPTH, and in HOLD always.
REQ-016 SHALL keep instr_addr_o stable from request until grant (HOLD keeps the pre-branch address); a request granted in HOLD is marked for discard.
REQ-017 SHALL on branch_i empty the FIFO in the same cycle, load the target as the next fetch address, and set discard count = outstanding at branch, minus 1 if rvalid arrives that cycle, plus any HOLD request.
REQ-018 SHALL drop responses while discard count>0, decrementing the count, with no FIFO write.
REQ-019 SHALL write each non-discarded rvalid to the FIFO tail as {rdata, word addr, instr_err_i}; valid_o rises one cycle after rvalid, with no bypass.
REQ-020 SHALL drive valid_o = FIFO non-empty & ~branch_i, and pop on valid_o & ready_i.
REQ-021 SHALL keep occupancy unchanged on a simultaneous push and pop; a push when full is impossible by the REQ-015 credit rule.
REQ-022 SHALL treat err as per-entry only: fetching continues after an error and err_o accompanies only its own entry.
REQ-023 SHALL leave already queued entries valid when req_i=0; only issue stops.

Reset
REQ-024 SHALL on rst_ni=0 at a clock edge set FSM=IDLE, FIFO empty, outstanding=0, discard=0, fetch address=0, stall_cnt_o=0.
REQ-025 SHALL make all outputs 0 while reset is sampled and for the first cycle after; responses to requests issued before reset are the bus's responsibility.
REQ-026 SHALL abandon a mid-HOLD request on reset (instr_req_o=0 next cycle).

Configuration
REQ-027 SHALL with CVE2_PREFETCH_PERF_EN defined increment stall_cnt_o, saturating at FFFF_FFFF, in each cycle with req_i=1, ready_i=1, valid_o=0.
REQ-028 SHALL without CVE2_PREFETCH_PERF_EN tie stall_cnt_o to 0 and include no counter flops.

Verification
REQ-029 SHALL cover streaming: branch to 0x100, gnt always 1, rvalid 1 cycle later -> valid_o entries with addr 0x100,0x104,0x108, one per cycle.
REQ-030 SHALL cover backpressure: ready_i=0, DEPTH=4, MAX_OUTS=2 -> at most 4 entries plus outstanding, instr_req_o drops, and no entry is lost after ready_i=1.
REQ-031 SHALL cover a branch with 2 outstanding: branch to 0x200 -> 2 responses dropped, first valid_o addr=0x200.
REQ-032 SHALL cover a branch during an ungranted request at 0x10C: instr_addr_o stays 0x10C until gnt, that response is discarded, then 0x300 is fetched.
REQ-033 SHALL cover an error response at 0x204 -> err_o=1 only with addr_o=0x204, and 0x208 follows with err_o=0.
REQ-034 SHALL cover PERF: 5 starved cycles -> stall_cnt_o=5, then reset -> 0; without the macro it stays 0.
